spi_txn_scheduler: RTL

//   Round-robin scheduler that shares one SPI Master among NUM_REQ host requesters.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_txn_scheduler_rr_arbiter.sv | 31 +++
 rtl/spi_txn_scheduler.sv | 116 +++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and codes for the SPI transaction scheduler.
// FSM states, SPI mode values and slave-select encodings.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE0 = 2'd0;
    localparam logic [1:0] MODE1 = 2'd1;
    localparam logic [1:0] MODE2 = 2'd2;
    localparam logic [1:0] MODE3 = 2'd3;

    localparam logic [1:0] SSI_NONE = 2'b00;
    localparam logic [1:0] SSI_S1   = 2'b01;
    localparam logic [1:0] SSI_S2   = 2'b10;
    localparam logic [1:0] SSI_S3   = 2'b11;

endpackage

// File: rtl/spi_txn_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps.
// Produces a one-hot grant and the matching index.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [IW-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = IW'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one SPI master among NUM_REQ read requesters, round-robin.
// Owns the per-slave mode table and times each transfer.
module spi_txn_scheduler
    import spi_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int XFER_CYCLES = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [2*NUM_REQ-1:0] req_ssi,
    input  logic [8*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_err,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_ssi,
    input  logic [1:0]           cfg_mode,
    output logic                 sendOrder,
    output logic [1:0]           ssi,
    output logic [7:0]           address,
    output logic [1:0]           mode,
    input  logic [7:0]           sensor,
    output logic                 busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;
    localparam logic [IW-1:0] LAST     = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(XFER_CYCLES - 1);

    state_t             state, state_nx;
    logic [IW-1:0]      ptr, gidx, arb_idx;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               arb_any;
    logic               grant;
    logic [CW-1:0]      cnt;
    logic [3:0][1:0]    mtab;
    logic [1:0]         sel_ssi;
    logic [7:0]         sel_addr;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IW     (IW)
    ) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .gnt(arb_gnt),
        .idx(arb_idx),
        .any(arb_any)
    );

    assign sel_ssi  = req_ssi[{arb_idx, 1'b0} +: 2];
    assign sel_addr = req_addr[{arb_idx, 3'b000} +: 8];
    assign grant    = (state == ST_IDLE) && arb_any;

    // Reset gates the accept pulse so every output is low while held.
    assign req_ready = (grant && reset) ? arb_gnt : '0;
    assign rsp_valid = (state == ST_DONE) ? (NUM_REQ'(1) << gidx) : '0;
    assign sendOrder = (state == ST_SEND);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (arb_any)
                    state_nx = (sel_ssi == SSI_NONE) ? ST_DONE : ST_SETUP;
            end
            ST_SETUP: state_nx = ST_SEND;
            ST_SEND:  state_nx = ST_WAIT;
            ST_WAIT:  if (cnt == '0) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gidx     <= '0;
            cnt      <= '0;
            mtab     <= {4{MODE0}};
            ssi      <= SSI_NONE;
            address  <= '0;
            mode     <= MODE0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (cfg_we && cfg_ssi != SSI_NONE)
                mtab[cfg_ssi] <= cfg_mode;
            // Grant reads the table before a same-cycle cfg write lands.
            if (grant) begin
                gidx     <= arb_idx;
                ptr      <= (arb_idx == LAST) ? '0 : arb_idx + 1'b1;
                ssi      <= sel_ssi;
                address  <= sel_addr;
                mode     <= mtab[sel_ssi];
                rsp_data <= '0;
                rsp_err  <= (sel_ssi == SSI_NONE);
            end
            if (state == ST_SEND)
                cnt <= CNT_LOAD;
            if (state == ST_WAIT) begin
                cnt <= cnt - 1'b1;
                if (cnt == '0)
                    rsp_data <= sensor;
            end
        end
    end

endmodule
